pwm_multichannel: RTL and testbench

Parametrised multi-channel PWM generator, successor to the fixed 16-output, 8-bit PWM peripheral behind the chip's SPI register file. It has per-channel double-buffered duty registers that update only at period boundaries, a programmable clock prescaler, per-channel output and PWM enables, and an optional center-aligned mode. It sits between the register file, which drives enables and duty writes, and the `uo_out`/`uio_out` pin mux.

---
 rtl/pwm_multichannel.sv | 214 +++++++++++++++++++++
 tb/tb_pwm_multichannel.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel.sv
// -----------------------------------------------------------------------------
// pwm_multichannel
//
// Multi-channel PWM generator with a shared prescaled period counter,
// per-channel double-buffered duty registers (shadow -> active at each period
// boundary), per-channel output/PWM enables and an optional center-aligned
// counting mode.
//
// Build option:
//   PWM_CENTER_ALIGN_EN - when defined, the center-aligned counter, its
//                         direction flag and the mode input are functional.
//                         When undefined the block is always edge-aligned and
//                         the mode input is accepted but ignored.
//
// Parameters:
//   NUM_CH  number of channels (1..32)
//   CNT_W   counter / duty width; P = 2^CNT_W - 1
//
// Ports:
//   clk           system clock, all state on the rising edge
//   rst           asynchronous active-high reset
//   en_out        per-channel output enable (0 forces the pin low)
//   en_pwm        per-channel PWM enable (0 with en_out=1 drives the pin high)
//   duty_we       duty write strobe, one cycle per write
//   duty_ch       channel index for the write (indices >= NUM_CH ignored)
//   duty_val      duty value written into the channel's shadow register
//   presc         prescaler, the counter advances every presc+1 clocks
//   mode          0 = edge-aligned, 1 = center-aligned (sampled at boundaries)
//   out           registered PWM outputs
//   period_start  one-clock pulse with the first output cycle of each period
// -----------------------------------------------------------------------------
module pwm_multichannel #(
    parameter  int NUM_CH = 16,
    parameter  int CNT_W  = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en_out,
    input  logic [NUM_CH-1:0] en_pwm,
    input  logic              duty_we,
    input  logic [CH_W-1:0]   duty_ch,
    input  logic [CNT_W-1:0]  duty_val,
    input  logic [7:0]        presc,
    input  logic              mode,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    // Highest counter value reached (P-1) and the value 1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** CNT_W) - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ---------------------------------------------------------------------
    // Prescaler: a tick fires whenever pcnt has reached (or passed) presc, so
    // lowering presc below the running count yields a tick on the next clock.
    // ---------------------------------------------------------------------
    logic [7:0] r_pcnt;
    logic       w_tick;

    assign w_tick = (r_pcnt >= presc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 8'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Period counter. w_wrap marks the step that would load cnt = 0; combined
    // with a tick that is a period boundary.
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_wrap;
    logic             w_boundary;

`ifdef PWM_CENTER_ALIGN_EN
    logic r_mode;
    logic r_dir_down;
    logic w_dir_down_next;
`else
    // The mode pin stays on the port list so the pin mux wiring does not
    // depend on the build option; it has no function in this build.
    logic w_unused_mode;
    assign w_unused_mode = mode;
`endif

    always_comb begin
        // Edge-aligned sawtooth: 0 .. P-1, then back to 0.
        if (r_cnt == CNT_LAST) begin
            w_cnt_next = '0;
            w_wrap     = 1'b1;
        end else begin
            w_cnt_next = r_cnt + 1'b1;
            w_wrap     = 1'b0;
        end
`ifdef PWM_CENTER_ALIGN_EN
        w_dir_down_next = r_dir_down;
        if (r_mode) begin
            // Triangle: up to P-1, down to 1, then the step to 0 closes the
            // period (so 0 and P-1 each appear once per period).
            w_wrap = 1'b0;
            if (r_dir_down) begin
                if (r_cnt == CNT_ONE) begin
                    w_cnt_next      = '0;
                    w_wrap          = 1'b1;
                    w_dir_down_next = 1'b0;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end else if (r_cnt == CNT_LAST) begin
                w_cnt_next      = CNT_LAST - 1'b1;
                w_dir_down_next = 1'b1;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
`endif
    end

    assign w_boundary = w_tick & w_wrap;

    // r_bnd_pend marks the cycle in which cnt first holds 0 after a boundary;
    // period_start is delayed one more clock to line up with the registered
    // outputs that reflect that counter value.
    logic r_bnd_pend;
    logic r_period_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_bnd_pend     <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_bnd_pend     <= w_boundary;
            r_period_start <= r_bnd_pend;
            if (w_tick) begin
                r_cnt <= w_cnt_next;
            end
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    // Mode is only latched at a boundary so a period never changes shape
    // part-way through; the direction is always "up" at that point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= 1'b0;
            r_dir_down <= 1'b0;
        end else begin
            if (w_tick) begin
                r_dir_down <= w_dir_down_next;
            end
            if (w_boundary) begin
                r_mode <= mode;
            end
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Per-channel duty registers and comparators. The boundary copy reads the
    // shadow's current value, so a write landing on the boundary cycle only
    // reaches the active register at the following boundary.
    // ---------------------------------------------------------------------
    logic [NUM_CH-1:0] w_raw;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_shadow;
            logic [CNT_W-1:0] r_active;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_shadow <= '0;
                    r_active <= '0;
                end else begin
                    if (duty_we && (duty_ch == CH_W'(gi))) begin
                        r_shadow <= duty_val;
                    end
                    if (w_boundary) begin
                        r_active <= r_shadow;
                    end
                end
            end

            // cnt never exceeds P-1, so an all-ones duty is a constant high.
            assign w_raw[gi] = (r_cnt < r_active);
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Output stage. Enables act on the next clock, independent of the period.
    // ---------------------------------------------------------------------
    logic [NUM_CH-1:0] r_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= en_out & (~en_pwm | w_raw);
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_multichannel.sv
// -----------------------------------------------------------------------------
// tb_pwm_multichannel
//
// Self-checking bench for pwm_multichannel. A behavioural model tracks the
// position inside the current period as a plain tick index and derives the
// counter value arithmetically; every clock the DUT outputs are compared with
// it. Directed scenarios also measure high-time and period length per channel
// between period_start pulses and compare them against hand-computed values.
// Build with +define+PWM_CENTER_ALIGN_EN to exercise the center-aligned mode.
// -----------------------------------------------------------------------------
module tb_pwm_multichannel;

    localparam int NUM_CH = 12;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 4;
    localparam int P      = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] en_out = '0;
    logic [NUM_CH-1:0] en_pwm = '0;
    logic              duty_we = 1'b0;
    logic [CH_W-1:0]   duty_ch = '0;
    logic [CNT_W-1:0]  duty_val = '0;
    logic [7:0]        presc = '0;
    logic              mode = 1'b0;
    logic [NUM_CH-1:0] out;
    logic              period_start;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_multichannel #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_out       (en_out),
        .en_pwm       (en_pwm),
        .duty_we      (duty_we),
        .duty_ch      (duty_ch),
        .duty_val     (duty_val),
        .presc        (presc),
        .mode         (mode),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- model
    int                m_since;      // clocks since the last tick
    int                m_pos;        // tick index inside the current period
    bit                m_center;     // shape of the current period
    bit                m_bnd_pend;
    int                m_shadow [NUM_CH];
    int                m_active [NUM_CH];
    logic [NUM_CH-1:0] m_out;
    logic              m_ps;

    // measurement between period_start pulses
    int acc_high  [NUM_CH];
    int last_high [NUM_CH];
    int acc_len;
    int last_len;
    int n_ps;

    function automatic int period_len();
        return m_center ? 2 * (P - 1) : P;
    endfunction

    // Counter value for the current period position.
    function automatic int model_cnt();
        if (m_center && (m_pos > P - 1)) return 2 * (P - 1) - m_pos;
        return m_pos;
    endfunction

    function automatic bit next_edge_is_boundary();
        return (m_since >= int'(presc)) && (m_pos == period_len() - 1);
    endfunction

    task automatic model_reset();
        m_since    = 0;
        m_pos      = 0;
        m_center   = 1'b0;
        m_bnd_pend = 1'b0;
        m_out      = '0;
        m_ps       = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge.
    task automatic model_step();
        int                c;
        logic [NUM_CH-1:0] raw;
        c = model_cnt();
        for (int i = 0; i < NUM_CH; i++) raw[i] = (c < m_active[i]);
        m_out      = en_out & (~en_pwm | raw);
        m_ps       = m_bnd_pend;
        m_bnd_pend = 1'b0;
        if (m_since >= int'(presc)) begin
            m_since = 0;
            m_pos   = m_pos + 1;
            if (m_pos == period_len()) begin
                m_pos      = 0;
                m_bnd_pend = 1'b1;
                for (int i = 0; i < NUM_CH; i++) m_active[i] = m_shadow[i];
`ifdef PWM_CENTER_ALIGN_EN
                m_center = mode;
`endif
            end
        end else begin
            m_since = m_since + 1;
        end
        if (duty_we && (int'(duty_ch) < NUM_CH)) m_shadow[duty_ch] = int'(duty_val);
    endtask

    // ------------------------------------------------------------ checking
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic measure_clear();
        acc_len  = 0;
        last_len = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_high[i]  = 0;
            last_high[i] = 0;
        end
    endtask

    task automatic measure();
        if (rst) begin
            measure_clear();
            return;
        end
        if (period_start) begin
            last_len  = acc_len;
            last_high = acc_high;
            acc_len   = 0;
            for (int i = 0; i < NUM_CH; i++) acc_high[i] = 0;
            n_ps++;
        end
        acc_len++;
        for (int i = 0; i < NUM_CH; i++) acc_high[i] += int'(out[i]);
    endtask

    // One clock: model at the rising edge, DUT sampled at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        chk("out", 32'(out), 32'(m_out));
        chk("period_start", 32'(period_start), 32'(m_ps));
        measure();
    endtask

    task automatic wait_periods(input int n);
        int target;
        int k;
        target = n_ps + n;
        k = 0;
        while ((n_ps < target) && (k < n * 2200 + 200)) begin
            cycle();
            k++;
        end
        chk("periods_seen", 32'(n_ps), 32'(target));
    endtask

    task automatic write_duty(input int ch, input int val);
        duty_we  = 1'b1;
        duty_ch  = CH_W'(ch);
        duty_val = CNT_W'(val);
        cycle();
        duty_we  = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        duty_we = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
    endtask

    task automatic chk_period(input string tag, input int len, input int ch, input int high);
        chk({tag, "_len"}, 32'(last_len), 32'(len));
        chk({tag, "_high"}, 32'(last_high[ch]), 32'(high));
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int seen_high;
        int k;

        model_reset();
        measure_clear();
        n_ps = 0;

        // Reset held with arbitrary inputs, including a duty write.
        rst = 1'b1; en_out = '1; en_pwm = '1; presc = 8'd0;
        duty_we = 1'b1; duty_ch = 4'd0; duty_val = 8'hAA;
        repeat (3) cycle();
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_pstart", 32'(period_start), 32'd0);
        duty_we = 1'b0;
        rst = 1'b0;

        // Duty 0 everywhere after reset: outputs stay low.
        seen_high = 0;
        repeat (300) begin
            cycle();
            if (out != '0) seen_high++;
        end
        chk("idle_high_cycles", 32'(seen_high), 32'd0);

        // Edge mode, duty 128 plus extremes and enables.
        write_duty(0, 128);
        write_duty(1, 0);
        write_duty(2, 255);
        write_duty(4, 7);
        write_duty(5, 200);
        write_duty(12, 99);
        en_pwm[4] = 1'b0;
        en_out[5] = 1'b0;
        wait_periods(2);
        chk_period("edge128", P, 0, 128);
        chk("duty0_high", 32'(last_high[1]), 32'd0);
        chk("duty255_high", 32'(last_high[2]), 32'(P));
        chk("pwm_off_high", 32'(last_high[4]), 32'(P));
        chk("out_off_high", 32'(last_high[5]), 32'd0);

        // Shadow update mid-period.
        write_duty(3, 200);
        wait_periods(1);
        repeat (100) cycle();
        write_duty(3, 64);
        wait_periods(1);
        chk("shadow_cur", 32'(last_high[3]), 32'd200);
        wait_periods(1);
        chk("shadow_next", 32'(last_high[3]), 32'd64);

        // Write landing exactly on the boundary cycle is deferred one period.
        k = 0;
        while (!next_edge_is_boundary() && (k < 600)) begin
            cycle();
            k++;
        end
        chk("bnd_found", 32'(next_edge_is_boundary()), 32'd1);
        write_duty(3, 150);
        wait_periods(1);
        wait_periods(1);
        chk("bnd_write_deferred", 32'(last_high[3]), 32'd64);
        wait_periods(1);
        chk("bnd_write_applied", 32'(last_high[3]), 32'd150);

        // Prescaler 3, duty 10.
        do_reset();
        en_out = '1; en_pwm = '1; presc = 8'd3;
        write_duty(0, 10);
        wait_periods(2);
        chk_period("presc3", 4 * P, 0, 40);

`ifdef PWM_CENTER_ALIGN_EN
        // Center mode, duty 64; mode change mid-period waits for the boundary.
        do_reset();
        presc = 8'd0; mode = 1'b1;
        write_duty(0, 64);
        wait_periods(2);
        chk_period("center64", 2 * (P - 1), 0, 127);
        repeat (200) cycle();
        mode = 1'b0;
        wait_periods(1);
        chk_period("center_keep", 2 * (P - 1), 0, 127);
        wait_periods(1);
        chk_period("edge_after", P, 0, 64);
`else
        // mode has no effect in the edge-only build.
        do_reset();
        presc = 8'd0; mode = 1'b1;
        write_duty(0, 64);
        wait_periods(2);
        chk_period("mode_ignored", P, 0, 64);
`endif

        // Randomised traffic against the model.
        do_reset();
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 99) < 15) begin
                duty_we = 1'b1;
                duty_ch = CH_W'($urandom_range(0, 15));
                case ($urandom_range(0, 3))
                    0:       duty_val = 8'd0;
                    1:       duty_val = 8'd255;
                    default: duty_val = CNT_W'($urandom_range(0, 255));
                endcase
            end else begin
                duty_we = 1'b0;
            end
            if ($urandom_range(0, 49) == 0) begin
                en_out = NUM_CH'($urandom);
                en_pwm = NUM_CH'($urandom);
            end
            if ($urandom_range(0, 299) == 0) presc = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) mode = ~mode;
            if ($urandom_range(0, 2999) == 0) begin
                duty_we = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("async_rst_out", 32'(out), 32'd0);
                chk("async_rst_pstart", 32'(period_start), 32'd0);
                model_reset();
                cycle();
                rst = 1'b0;
            end
            cycle();
        end
        duty_we = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
